// File: rtl/pc_sequencer_if.sv
// Signal bundle between pc_sequencer, the control unit, the flags register,
// instruction memory and the mx_pc/adder pair.
interface pc_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             stall;
   logic             imem_ack;
   logic             exec_done;
   logic [1:0]       jump_type;
   logic [2:0]       cond;
   logic [3:0]       flags;
   logic             halt;
   logic [31:0]      pc_next;
   logic [1:0]       S_MXPC;
   logic [31:0]      pc;
   logic             imem_req;
   logic             instr_valid;
   logic             pc_we;
   logic             halted;
   logic [CNT_W-1:0] taken_cnt;

   modport master (
      input  stall, imem_ack, exec_done, jump_type, cond, flags, halt, pc_next,
      output S_MXPC, pc, imem_req, instr_valid, pc_we, halted, taken_cnt
   );

   modport slave (
      output stall, imem_ack, exec_done, jump_type, cond, flags, halt, pc_next,
      input  S_MXPC, pc, imem_req, instr_valid, pc_we, halted, taken_cnt
   );
endinterface

// File: rtl/pc_sequencer.sv
// Instruction-fetch controller: owns the PC, handshakes fetches with imem and
// selects the next-PC source on mx_pc, loading its output back into the PC.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h00000000,
   parameter int          CNT_W    = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   pc_sequencer_if.master bus
);
   typedef enum logic [1:0] {BOOT, FETCH, EXEC, HALT} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   logic [31:0]      r_pc;
   logic [CNT_W-1:0] r_takenCnt;

   logic       w_flagBit;
   logic       w_condTrue;
   logic [1:0] w_sel;
   logic       w_fetchReq;
   logic       w_accept;
   logic       w_commit;

   // cond[2:1] picks the flag (Z,N,C,O), cond[0] inverts it.
   always_comb begin
      w_flagBit = 1'b0;
      case (bus.cond[2:1])
         2'b00:   w_flagBit = bus.flags[0];
         2'b01:   w_flagBit = bus.flags[1];
         2'b10:   w_flagBit = bus.flags[2];
         default: w_flagBit = bus.flags[3];
      endcase
   end

   assign w_condTrue = w_flagBit ^ bus.cond[0];

   always_comb begin
      w_sel = 2'b10;
      if (r_state == EXEC) begin
         case (bus.jump_type)
            2'b00:   w_sel = 2'b10;
            2'b01:   w_sel = 2'b00;
            2'b10:   w_sel = 2'b01;
            default: w_sel = w_condTrue ? 2'b00 : 2'b10;
         endcase
      end
   end

   assign w_fetchReq = (r_state == FETCH) && !bus.stall;
   assign w_accept   = w_fetchReq && bus.imem_ack;
   assign w_commit   = (r_state == EXEC) && bus.exec_done;

   // Anything other than the sequential select counts as a taken jump.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= BOOT;
         r_pc       <= RESET_PC;
         r_takenCnt <= '0;
      end else begin
         case (r_state)
            BOOT:  r_state <= FETCH;
            FETCH: if (w_accept) r_state <= EXEC;
            EXEC: begin
               if (bus.exec_done) begin
                  r_pc    <= bus.pc_next;
                  r_state <= bus.halt ? HALT : FETCH;
                  if (w_sel != 2'b10) r_takenCnt <= r_takenCnt + CNT_ONE;
               end
            end
            default: r_state <= HALT;
         endcase
      end
   end

   assign bus.S_MXPC      = w_sel;
   assign bus.pc          = r_pc;
   assign bus.imem_req    = w_fetchReq;
   assign bus.instr_valid = w_accept;
   assign bus.pc_we       = w_commit;
   assign bus.halted      = (r_state == HALT);
   assign bus.taken_cnt   = r_takenCnt;
endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against a jump-rule reference model.
module tb_pc_sequencer;
   localparam logic [31:0] RESET_PC = 32'h00000000;
   localparam int          CNT_W    = 4;

   logic clk = 1'b0;
   logic rst_n;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] modelPc;
   int          modelCnt;

   pc_sequencer_if #(.CNT_W(CNT_W)) bus ();

   pc_sequencer #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic bit condHolds(input logic [2:0] c, input logic [3:0] f);
      bit o, cy, n, z;
      {o, cy, n, z} = f;
      case (c)
         3'd0:    return z;
         3'd1:    return !z;
         3'd2:    return n;
         3'd3:    return !n;
         3'd4:    return cy;
         3'd5:    return !cy;
         3'd6:    return o;
         default: return !o;
      endcase
   endfunction

   function automatic logic [1:0] expectedSel(input logic [1:0] jt, input logic [2:0] c, input logic [3:0] f);
      case (jt)
         2'd0:    return 2'b10;
         2'd1:    return 2'b00;
         2'd2:    return 2'b01;
         default: return condHolds(c, f) ? 2'b00 : 2'b10;
      endcase
   endfunction

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic applyStimulus(input logic s, input logic a, input logic d, input logic [1:0] jt,
                                input logic [2:0] c, input logic [3:0] f, input logic h, input logic [31:0] pn);
      @(negedge clk);
      bus.stall     = s;
      bus.imem_ack  = a;
      bus.exec_done = d;
      bus.jump_type = jt;
      bus.cond      = c;
      bus.flags     = f;
      bus.halt      = h;
      bus.pc_next   = pn;
      #1;
   endtask

   task automatic applyIdle();
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 32'd0);
   endtask

   task automatic doFetch(input int stallCycles);
      for (int i = 0; i < stallCycles; i++) begin
         applyStimulus(1'b1, 1'b1, 1'($urandom), 2'($urandom), 3'($urandom), 4'($urandom), 1'($urandom), $urandom);
         checkOutput("stall_req", 32'(bus.imem_req), 0);
         checkOutput("stall_valid", 32'(bus.instr_valid), 0);
         checkOutput("stall_we", 32'(bus.pc_we), 0);
         checkOutput("stall_pc", bus.pc, modelPc);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 2'($urandom), 3'($urandom), 4'($urandom), 1'($urandom), $urandom);
      checkOutput("fetch_req", 32'(bus.imem_req), 1);
      checkOutput("fetch_valid", 32'(bus.instr_valid), 1);
      checkOutput("fetch_pc", bus.pc, modelPc);
   endtask

   task automatic doExec(input int idleCycles, input logic [1:0] jt, input logic [2:0] c,
                         input logic [3:0] f, input logic h, input logic [31:0] pn);
      logic [1:0] expSel;
      for (int i = 0; i < idleCycles; i++) begin
         applyStimulus(1'($urandom), 1'($urandom), 1'b0, 2'($urandom), 3'($urandom), 4'($urandom), 1'($urandom), $urandom);
         checkOutput("wait_we", 32'(bus.pc_we), 0);
         checkOutput("wait_req", 32'(bus.imem_req), 0);
         checkOutput("wait_valid", 32'(bus.instr_valid), 0);
         checkOutput("wait_pc", bus.pc, modelPc);
      end
      applyStimulus(1'($urandom), 1'($urandom), 1'b1, jt, c, f, h, pn);
      expSel = expectedSel(jt, c, f);
      checkOutput("exec_sel", 32'(bus.S_MXPC), 32'(expSel));
      checkOutput("exec_we", 32'(bus.pc_we), 1);
      checkOutput("exec_req", 32'(bus.imem_req), 0);
      modelPc = pn;
      if (expSel != 2'b10) modelCnt = (modelCnt + 1) % (1 << CNT_W);
      applyIdle();
      checkOutput("post_pc", bus.pc, modelPc);
      checkOutput("post_cnt", 32'(bus.taken_cnt), 32'(modelCnt));
      checkOutput("post_halted", 32'(bus.halted), 32'(h));
      checkOutput("post_req", 32'(bus.imem_req), 32'(!h));
      checkOutput("post_sel", 32'(bus.S_MXPC), 32'(2'b10));
   endtask

   initial begin
      logic [3:0] sweepFlags [2];
      sweepFlags[0] = 4'b0101;
      sweepFlags[1] = 4'b1010;

      rst_n = 1'b0;
      bus.stall = 1'b0; bus.imem_ack = 1'b0; bus.exec_done = 1'b0; bus.jump_type = 2'd0;
      bus.cond = 3'd0; bus.flags = 4'd0; bus.halt = 1'b0; bus.pc_next = 32'd0;
      modelPc  = RESET_PC;
      modelCnt = 0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_pc", bus.pc, RESET_PC);
      checkOutput("rst_sel", 32'(bus.S_MXPC), 32'(2'b10));
      checkOutput("rst_req", 32'(bus.imem_req), 0);
      checkOutput("rst_valid", 32'(bus.instr_valid), 0);
      checkOutput("rst_we", 32'(bus.pc_we), 0);
      checkOutput("rst_halted", 32'(bus.halted), 0);
      checkOutput("rst_cnt", 32'(bus.taken_cnt), 0);

      // Cycle 1 is BOOT, cycle 2 is FETCH without ack, cycle 3 acks.
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("boot_req", 32'(bus.imem_req), 0);
      applyIdle();
      checkOutput("c2_req", 32'(bus.imem_req), 1);
      checkOutput("c2_valid", 32'(bus.instr_valid), 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 4'd0, 1'b0, 32'd0);
      checkOutput("c3_valid", 32'(bus.instr_valid), 1);
      applyIdle();
      checkOutput("c4_valid", 32'(bus.instr_valid), 0);
      checkOutput("c4_req", 32'(bus.imem_req), 0);
      checkOutput("c4_pc", bus.pc, 32'd0);

      doExec(0, 2'd0, 3'd0, 4'd0, 1'b0, 32'h00000001);
      doFetch(0);
      doExec(1, 2'd1, 3'd0, 4'd0, 1'b0, 32'hFFFF0000);
      doFetch(0);
      doExec(0, 2'd2, 3'd0, 4'd0, 1'b0, 32'h0000FFFF);

      for (int fi = 0; fi < 2; fi++) begin
         for (int c = 0; c < 8; c++) begin
            doFetch($urandom_range(0, 2));
            doExec($urandom_range(0, 2), 2'd3, 3'(c), sweepFlags[fi], 1'b0, $urandom);
         end
      end

      doFetch(3);
      doExec(0, 2'd1, 3'd0, 4'd0, 1'b0, $urandom);

      for (int i = 0; i < 30; i++) begin
         doFetch($urandom_range(0, 2));
         doExec($urandom_range(0, 3), 2'($urandom), 3'($urandom), 4'($urandom), 1'b0, $urandom);
      end

      // Asynchronous reset in the middle of an EXEC cycle.
      doFetch(0);
      doExec(0, 2'd0, 3'd0, 4'd0, 1'b0, 32'hDEADBEEF);
      doFetch(1);
      applyStimulus(1'b0, 1'b1, 1'b0, 2'd1, 3'd0, 4'd0, 1'b0, 32'h12345678);
      #2;
      rst_n = 1'b0;
      #1;
      modelPc  = RESET_PC;
      modelCnt = 0;
      checkOutput("async_pc", bus.pc, RESET_PC);
      checkOutput("async_cnt", 32'(bus.taken_cnt), 0);
      checkOutput("async_sel", 32'(bus.S_MXPC), 32'(2'b10));
      checkOutput("async_req", 32'(bus.imem_req), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("boot2_req", 32'(bus.imem_req), 0);

      doFetch(1);
      doExec(0, 2'd1, 3'd0, 4'd0, 1'b0, 32'h00000100);
      doFetch(0);
      doExec(1, 2'd1, 3'd0, 4'd0, 1'b1, 32'h00000200);

      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 2'($urandom), 3'($urandom), 4'($urandom), 1'($urandom), $urandom);
         checkOutput("halt_halted", 32'(bus.halted), 1);
         checkOutput("halt_req", 32'(bus.imem_req), 0);
         checkOutput("halt_valid", 32'(bus.instr_valid), 0);
         checkOutput("halt_we", 32'(bus.pc_we), 0);
         checkOutput("halt_sel", 32'(bus.S_MXPC), 32'(2'b10));
         checkOutput("halt_pc", bus.pc, modelPc);
         checkOutput("halt_cnt", 32'(bus.taken_cnt), 32'(modelCnt));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
